// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM state type for the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_INV  = 4'b0100;
    localparam logic [3:0] OP_SUB  = OP_ADD | OP_INV;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_MULS = 4'b1001;

    // f[INV_BIT] inverts B and supplies the carry-in for subtract/compare.
    localparam int INV_BIT = 2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

endpackage

// File: rtl/alu_seq_core.sv
// Combinational single-cycle datapath: logic ops, add/subtract, signed set-less-than,
// plus carry and signed-overflow flags.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf_add;

    always_comb begin
        b_eff   = f[INV_BIT] ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, f[INV_BIT]};
        ovf_add = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

        // NOTE: every output gets a default before the case so no latch is inferred.
        y     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (f[1:0])
            OP_AND[1:0]: y = a & b_eff;
            OP_OR[1:0]:  y = a | b_eff;
            OP_ADD[1:0]: begin
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = ovf_add;
            end
            // Sign of the exact difference: raw sign bit corrected by overflow.
            OP_SLT[1:0]: y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_add};
            default:     y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops via alu_seq_core, unsigned/signed multiply by
// iterative shift-add over WIDTH cycles, registered result and flags.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               neg_q, neg_d;
    logic               muls_q, muls_d;
    logic [WIDTH-1:0]   y_q, y_d, y_hi_q, y_hi_d;
    logic               zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

    logic [WIDTH-1:0]   core_y;
    logic               core_carry, core_ovf;
    logic [WIDTH:0]     acc;
    logic [2*WIDTH-1:0] prod_step, prod_fin;
    logic               a_neg, b_neg;

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .a     (a),
        .b     (b),
        .f     (f[2:0]),
        .y     (core_y),
        .carry (core_carry),
        .ovf   (core_ovf)
    );

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign y_hi      = y_hi_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        muls_d  = muls_q;
        y_d     = y_q;
        y_hi_d  = y_hi_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        // One shift-add step: conditionally add multiplicand into the high half, shift right.
        acc       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {acc, prod_q[WIDTH-1:1]};
        prod_fin  = neg_q ? (~prod_step + 1'b1) : prod_step;

        a_neg = (f == OP_MULS) && a[WIDTH-1];
        b_neg = (f == OP_MULS) && b[WIDTH-1];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (f == OP_MULU || f == OP_MULS) begin
                        mcand_d = a_neg ? (~a + 1'b1) : a;
                        prod_d  = {{WIDTH{1'b0}}, (b_neg ? (~b + 1'b1) : b)};
                        neg_d   = a_neg ^ b_neg;
                        muls_d  = (f == OP_MULS);
                        cnt_d   = CNT_LOAD;
                        state_d = BUSY;
                    end else if (f[3]) begin
                        y_d     = '0;
                        y_hi_d  = '0;
                        zero_d  = 1'b1;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        y_d     = core_y;
                        y_hi_d  = '0;
                        zero_d  = (core_y == '0);
                        carry_d = core_carry;
                        ovf_d   = core_ovf;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                prod_d = prod_step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) begin
                    y_d     = prod_fin[WIDTH-1:0];
                    y_hi_d  = prod_fin[2*WIDTH-1:WIDTH];
                    zero_d  = (prod_fin == '0);
                    carry_d = 1'b0;
                    ovf_d   = muls_q ? (prod_fin[2*WIDTH-1:WIDTH] != {WIDTH{prod_fin[WIDTH-1]}})
                                     : (prod_fin[2*WIDTH-1:WIDTH] != '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            muls_q  <= 1'b0;
            y_q     <= '0;
            y_hi_q  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            muls_q  <= muls_d;
            y_q     <= y_d;
            y_hi_q  <= y_hi_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model.
module tb_alu_seq;

    typedef struct packed {
        logic [31:0] y;
        logic [31:0] y_hi;
        logic        zero;
        logic        carry;
        logic        ovf;
        logic [31:0] lat;
        logic [31:0] acc;
        logic        seen;
    } exp_t;

    logic        clk, rst_n, in_valid, out_ready, sel;
    logic [31:0] a, b;
    logic [3:0]  f;

    logic        rdy32, ov32, z32, c32, o32;
    logic [31:0] y32, yh32;
    logic        rdy8, ov8, z8, c8, o8;
    logic [7:0]  y8, yh8;

    int   cyc = 0, errors = 0, checks = 0, last_acc = 0, last_hs = 0, rmode = 0;
    exp_t q32[$];
    exp_t q8[$];

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(rdy32),
        .a(a), .b(b), .f(f), .out_valid(ov32), .out_ready(out_ready),
        .y(y32), .y_hi(yh32), .zero(z32), .carry(c32), .ovf(o32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(rdy8),
        .a(a[7:0]), .b(b[7:0]), .f(f), .out_valid(ov8), .out_ready(out_ready),
        .y(y8), .y_hi(yh8), .zero(z8), .carry(c8), .ovf(o8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        case (rmode)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint sx(input int w, input logic [31:0] v);
        return v[w-1] ? longint'(v) - (longint'(1) << w) : longint'(v);
    endfunction

    // Reference model: exact integer arithmetic, results truncated to w bits.
    function automatic exp_t model(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                   input logic [3:0] fi);
        exp_t e;
        longint unsigned mask, pu;
        longint sa, sb, r, p, lim, cin;
        logic [31:0] bb;
        mask = (64'd1 << w) - 1;
        lim  = longint'(1) << (w - 1);
        e = '0;
        e.lat = 1;
        if (!fi[3]) begin
            cin = longint'(fi[2]);
            bb  = fi[2] ? (~bi & mask[31:0]) : bi;
            sa  = sx(w, ai);
            sb  = sx(w, bb);
            r   = sa + sb + cin;
            case (fi[1:0])
                2'b00: e.y = ai & bb;
                2'b01: e.y = ai | bb;
                2'b10: begin
                    pu      = longint'(ai) + longint'(bb) + cin;
                    e.y     = pu[31:0] & mask[31:0];
                    e.carry = ((pu >> w) & 1) != 0;
                    e.ovf   = (r < -lim) || (r >= lim);
                end
                default: e.y = {31'd0, r < 0};
            endcase
            e.zero = (e.y == 0);
        end else if (fi == 4'b1000) begin
            pu       = longint'(ai) * longint'(bi);
            e.y      = pu[31:0] & mask[31:0];
            pu       = pu >> w;
            e.y_hi   = pu[31:0] & mask[31:0];
            e.ovf    = (pu != 0);
            e.zero   = (longint'(ai) * longint'(bi)) == 0;
            e.lat    = w + 1;
        end else if (fi == 4'b1001) begin
            p        = sx(w, ai) * sx(w, bi);
            pu       = p;
            e.y      = pu[31:0] & mask[31:0];
            pu       = p >>> w;
            e.y_hi   = pu[31:0] & mask[31:0];
            e.ovf    = (p < -lim) || (p >= lim);
            e.zero   = (p == 0);
            e.lat    = w + 1;
        end else begin
            e.zero = 1'b1;
        end
        return e;
    endfunction

    task automatic mon(input int id, input logic ov, input logic [31:0] ya, input logic [31:0] yha,
                       input logic za, input logic ca, input logic oa);
        exp_t  e;
        string tag;
        tag = (id == 0) ? "w32" : "w8";
        if (!ov) return;
        if ((id == 0 ? q32.size() : q8.size()) == 0) begin
            check({tag, " unexpected out_valid"}, ov, 1'b0);
            return;
        end
        e = (id == 0) ? q32[0] : q8[0];
        if (!e.seen) begin
            check({tag, " latency"}, cyc + 1 - int'(e.acc), e.lat);
            if (id == 0) q32[0].seen = 1'b1; else q8[0].seen = 1'b1;
        end
        check({tag, " y"}, ya, e.y);
        check({tag, " y_hi"}, yha, e.y_hi);
        check({tag, " zero"}, za, e.zero);
        check({tag, " carry"}, ca, e.carry);
        check({tag, " ovf"}, oa, e.ovf);
        if (out_ready) begin
            if (id == 0) void'(q32.pop_front()); else void'(q8.pop_front());
            last_hs = cyc + 1;
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            mon(0, ov32, y32, yh32, z32, c32, o32);
            mon(1, ov8, {24'd0, y8}, {24'd0, yh8}, z8, c8, o8);
        end
    end

    task automatic issue(input logic [31:0] ai, input logic [31:0] bi, input logic [3:0] fi);
        int          w, n;
        logic [31:0] m;
        exp_t        e;
        w = sel ? 8 : 32;
        m = sel ? 32'hFF : 32'hFFFF_FFFF;
        n = 0;
        @(negedge clk);
        a = ai & m;
        b = bi & m;
        f = fi;
        in_valid = 1'b1;
        while (!(sel ? rdy8 : rdy32)) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                check("in_ready timeout", sel ? rdy8 : rdy32, 1'b1);
                in_valid = 1'b0;
                return;
            end
        end
        e = model(w, a, b, f);
        e.acc = cyc + 1;
        last_acc = cyc + 1;
        if (sel) q8.push_back(e); else q32.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() + q8.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain queues", q32.size() + q8.size(), 0);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return sel ? 32'h80 : 32'h8000_0000;
            3:       return sel ? 32'h7F : 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic suite();
        int          n;
        logic [31:0] msb;
        msb = sel ? 32'h80 : 32'h8000_0000;
        rmode = 2;
        issue(msb - 1, 32'd1, 4'b0010);
        issue(32'd5, 32'd5, 4'b0110);
        issue(msb, 32'd1, 4'b0111);
        issue(32'd1, msb, 4'b0111);
        issue(32'hFFFF_FFFF, sel ? 32'hFF : 32'd2, 4'b1000);
        issue(32'hFFFF_FFFD, 32'd7, 4'b1001);
        issue(32'h1234_5678, 32'h9ABC_DEF0, 4'b1111);
        drain();

        // Backpressure: hold out_ready low with a result pending and new requests offered.
        rmode = 1;
        issue(32'h0000_0003, 32'h0000_0004, 4'b0010);
        n = 0;
        while (!(sel ? ov8 : ov32) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp out_valid", sel ? ov8 : ov32, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 32'h11;
            b = 32'h22;
            f = 4'b0001;
            in_valid = 1'b1;
            #3;
            check("bp in_ready", sel ? rdy8 : rdy32, 1'b0);
        end
        in_valid = 1'b0;
        rmode = 2;
        issue(32'h0000_0010, 32'h0000_0001, 4'b0110);
        check("accept after handshake", last_acc - last_hs, 1);
        drain();

        rmode = 0;
        for (int i = 0; i < 120; i++) issue(rand_op(), rand_op(), 4'($urandom_range(0, 15)));
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        sel = 1'b0;
        a = '0;
        b = '0;
        f = '0;
        @(negedge clk);
        @(negedge clk);
        #3;
        check("reset out_valid w32", ov32, 1'b0);
        check("reset in_ready w32", rdy32, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        #3;
        check("in_ready after reset w32", rdy32, 1'b1);

        sel = 1'b0;
        suite();
        sel = 1'b1;
        suite();

        // Reset mid-multiply aborts the op: no result may follow.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            issue(32'hFFFF_FFFF, 32'h0000_0003, 4'b1000);
            repeat (4) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            #3;
            check("abort out_valid", sel ? ov8 : ov32, 1'b0);
            check("abort y", sel ? {24'd0, y8} : y32, 32'd0);
            check("abort y_hi", sel ? {24'd0, yh8} : yh32, 32'd0);
            check("abort flags", sel ? {z8, c8, o8} : {z32, c32, o32}, 3'b000);
            check("abort in_ready", sel ? rdy8 : rdy32, 1'b0);
            @(negedge clk);
            q32.delete();
            q8.delete();
            rst_n = 1'b1;
            #3;
            check("in_ready after release", sel ? rdy8 : rdy32, 1'b1);
            repeat (40) @(negedge clk);
            issue(32'h0000_0006, 32'h0000_0007, 4'b1001);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
